// File: rtl/bcd_to_bin_if.sv
// Handshake bundle for the BCD-to-binary converter: start/bcd_in in, busy/done/bin_out/err out.
// Latency: n/a (wiring only).
// Backpressure: none; the requester watches busy, and a start while busy is ignored.
interface bcd_to_bin_if #(
    parameter int DIGITS = 3,
    parameter int BIN_W  = 10
);
    logic                  start;
    logic [4*DIGITS-1:0]   bcd_in;
    logic                  busy;
    logic                  done;
    logic [BIN_W-1:0]      bin_out;
    logic                  err;

    modport master (output start, bcd_in, input busy, done, bin_out, err);
    modport slave  (input start, bcd_in, output busy, done, bin_out, err);
endinterface

// File: rtl/bcd_to_bin.sv
// Packed BCD to binary converter, acc = acc*10 + digit, one digit per clock, MSD first.
// Latency: start sampled at edge k -> done/bin_out valid in the cycle after edge k+DIGITS.
// Backpressure: start is ignored while busy. Optional macro BCD_CHECK_EN flags digits > 9 on err.
module bcd_to_bin #(
    parameter int DIGITS = 3,
    parameter int BIN_W  = 10
) (
    input  logic        clk,
    input  logic        reset_n,
    bcd_to_bin_if.slave bus
);
    localparam int CNT_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DIGITS - 1);

    typedef enum logic {IDLE, CONV} state_t;

    state_t              state;
    state_t              state_nxt;
    logic [4*DIGITS-1:0] shreg;
    logic [BIN_W-1:0]    acc;
    logic [BIN_W-1:0]    acc_nxt;
    logic [CNT_W-1:0]    cnt;
    logic [3:0]          digit;
    logic                accept;
    logic                last_digit;
    logic                done_q;
    logic [BIN_W-1:0]    bin_q;

    assign digit      = shreg[4*DIGITS-1 -: 4];
    assign accept     = (state == IDLE) && bus.start;
    assign last_digit = (state == CONV) && (cnt == LAST_CNT);

    // acc*10 as two shifts plus the digit, at BIN_W+4 bits, then truncated back to BIN_W.
    assign acc_nxt = BIN_W'(({4'b0000, acc} << 3) + ({4'b0000, acc} << 1)
                            + (BIN_W + 4)'(digit));

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    // Next state: leave IDLE on an accepted start, return after the LSD is consumed.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.start) state_nxt = CONV;
            CONV:    if (cnt == LAST_CNT) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath: latch input on accept, then shift one digit into the accumulator per cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            shreg  <= '0;
            acc    <= '0;
            cnt    <= '0;
            done_q <= 1'b0;
            bin_q  <= '0;
        end else begin
            done_q <= last_digit;
            if (accept) begin
                shreg <= bus.bcd_in;
                acc   <= '0;
                cnt   <= '0;
            end else if (state == CONV) begin
                acc   <= acc_nxt;
                shreg <= shreg << 4;
                cnt   <= cnt + 1'b1;
                if (last_digit) bin_q <= acc_nxt;
            end
        end
    end

`ifdef BCD_CHECK_EN
    logic bad_seen;
    logic err_q;

    // Sticky bad-digit flag; err is published alongside done and cleared by the next start.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bad_seen <= 1'b0;
            err_q    <= 1'b0;
        end else if (accept) begin
            bad_seen <= 1'b0;
            err_q    <= 1'b0;
        end else if (state == CONV) begin
            bad_seen <= bad_seen | (digit > 4'd9);
            if (last_digit) err_q <= bad_seen | (digit > 4'd9);
        end
    end

    assign bus.err = err_q;
`else
    assign bus.err = 1'b0;
`endif

    assign bus.busy    = (state == CONV);
    assign bus.done    = done_q;
    assign bus.bin_out = bin_q;
endmodule

// File: tb/tb_bcd_to_bin.sv
// Directed bench for bcd_to_bin with a scoreboard queue checked on every done pulse.
// Latency: checks busy/done timing against start-to-done of DIGITS+1 cycles.
// Backpressure: exercises start-while-busy and start held across done.
module tb_bcd_to_bin;
    localparam int DIGITS = 3;
    localparam int BIN_W  = 10;

    typedef struct packed {
        logic [BIN_W-1:0] bin;
        logic             err;
    } exp_t;

    logic clk;
    logic reset_n;
    int   total;
    int   passed;
    int   done_cnt;
    exp_t sb[$];

    bcd_to_bin_if #(.DIGITS(DIGITS), .BIN_W(BIN_W)) bus ();

    bcd_to_bin #(.DIGITS(DIGITS), .BIN_W(BIN_W)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    endtask

    // Reference: decimal weighting of the raw digit values.
    function automatic exp_t model(input logic [4*DIGITS-1:0] b);
        exp_t e;
        int   acc;
        logic bad;
        acc = 0;
        bad = 1'b0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            acc = acc * 10 + int'(b[4*i +: 4]);
            if (b[4*i +: 4] > 4'd9) bad = 1'b1;
        end
        e.bin = BIN_W'(acc);
`ifdef BCD_CHECK_EN
        e.err = bad;
`else
        e.err = 1'b0;
`endif
        return e;
    endfunction

    // Monitor: every done pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (reset_n && bus.done) begin
            exp_t e;
            done_cnt++;
            check("sb_has_entry", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check("bin_out", 32'(bus.bin_out), 32'(e.bin));
                check("err", 32'(bus.err), 32'(e.err));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic launch(input logic [4*DIGITS-1:0] b);
        bus.bcd_in = b;
        bus.start  = 1'b1;
        sb.push_back(model(b));
        tick();
        bus.start  = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int prev;
        prev = done_cnt;
        for (int i = 0; i < 20 && done_cnt == prev; i++) tick();
        check(tag, 32'(done_cnt), 32'(prev + 1));
    endtask

    initial begin
        int prev;
        total    = 0;
        passed   = 0;
        done_cnt = 0;
        reset_n  = 1'b0;
        bus.start  = 1'b0;
        bus.bcd_in = '0;

        // Reset state
        repeat (3) @(posedge clk);
        #2;
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_bin", 32'(bus.bin_out), 32'd0);
        check("rst_err", 32'(bus.err), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        tick();

        // Idle: no spurious done
        prev = done_cnt;
        repeat (10) tick();
        check("idle_no_done", 32'(done_cnt), 32'(prev));

        // Basic conversion with cycle-exact timing
        launch(12'h472);
        for (int i = 0; i < DIGITS; i++) begin
            check("lat_busy", 32'(bus.busy), 32'd1);
            check("lat_done_low", 32'(bus.done), 32'd0);
            tick();
        end
        check("lat_done", 32'(bus.done), 32'd1);
        check("lat_idle", 32'(bus.busy), 32'd0);
        check("lat_bin", 32'(bus.bin_out), 32'd472);
        tick();
        check("done_one_cycle", 32'(bus.done), 32'd0);
        check("bin_held", 32'(bus.bin_out), 32'd472);

        // Boundaries
        launch(12'h999); wait_done("to_999");
        launch(12'h000); wait_done("to_000");
        launch(12'h100); wait_done("to_100");

        // start while busy is ignored, even with a new bcd_in
        launch(12'h123);
        bus.bcd_in = 12'h555;
        bus.start  = 1'b1;
        tick();
        bus.start  = 1'b0;
        wait_done("busy_ignore");
        prev = done_cnt;
        repeat (6) tick();
        check("no_extra_done", 32'(done_cnt), 32'(prev));

        // start held across done -> back-to-back
        bus.bcd_in = 12'h123;
        bus.start  = 1'b1;
        sb.push_back(model(12'h123));
        tick();
        bus.bcd_in = 12'h555;
        sb.push_back(model(12'h555));
        wait_done("b2b_first");
        tick();
        bus.start  = 1'b0;
        check("b2b_busy", 32'(bus.busy), 32'd1);
        wait_done("b2b_second");

        // Reset mid-conversion aborts without done
        launch(12'h876);
        tick();
        tick();
        #2;
        reset_n = 1'b0;
        #1;
        check("abort_busy", 32'(bus.busy), 32'd0);
        check("abort_done", 32'(bus.done), 32'd0);
        check("abort_bin", 32'(bus.bin_out), 32'd0);
        sb.delete();
        prev = done_cnt;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (5) tick();
        check("abort_no_done", 32'(done_cnt), 32'(prev));
        launch(12'h042); wait_done("after_abort");

        // Non-decimal digit: raw arithmetic, err depends on build
        launch(12'h3A1); wait_done("bad_digit");
        check("bad_bin_held", 32'(bus.bin_out), 32'd401);
        launch(12'h301); wait_done("clean_after_bad");
        check("clean_err", 32'(bus.err), 32'd0);

        repeat (3) tick();
        check("sb_drained", 32'(sb.size()), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end
endmodule
